// File: rtl/imem_port_arbiter.sv
// Arbitrates the single-port instruction BSRAM between CPU fetch (read-only) and the program loader.
// Fetch is held off in BOOT until the loader signals completion; in RUN the loader has priority with a fetch starvation guard.
module imem_port_arbiter #(
  parameter int AW         = 11,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 8,
  parameter bit BOOT_HOLD  = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [DW-1:0] ld_rdata,
  input  logic          ld_boot_done,
  output logic          boot_busy,
  output logic          mem_ce,
  output logic          mem_oce,
  output logic          mem_wre,
  output logic [AW-1:0] mem_ad,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  typedef enum logic {ST_BOOT, ST_RUN} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LD} owner_t;

  state_t        state, state_nxt;
  logic [CW-1:0] starve_cnt, starve_cnt_nxt;
  owner_t        rd_owner_p1, rd_owner_nxt;
  logic          prio_if;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT_HOLD ? ST_BOOT : ST_RUN;
      starve_cnt  <= '0;
      rd_owner_p1 <= OWN_NONE;
    end else begin
      state       <= state_nxt;
      starve_cnt  <= starve_cnt_nxt;
      rd_owner_p1 <= rd_owner_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = '0;
    if_gnt         = 1'b0;
    ld_gnt         = 1'b0;
    prio_if        = 1'b0;
    case (state)
      ST_BOOT: begin
        // Fetch stays blocked even in the cycle ld_boot_done arrives
        ld_gnt = ld_req;
        if (ld_boot_done) state_nxt = ST_RUN;
      end
      default: begin
        prio_if = (starve_cnt == CNT_MAX);
        if_gnt  = if_req & (~ld_req | prio_if);
        ld_gnt  = ld_req & ~if_gnt;
        if (if_req && !if_gnt)
          starve_cnt_nxt = prio_if ? CNT_MAX : starve_cnt + CW'(1);
      end
    endcase
  end

  always_comb begin
    rd_owner_nxt = OWN_NONE;
    if (if_gnt)                rd_owner_nxt = OWN_IF;
    else if (ld_gnt && !ld_we) rd_owner_nxt = OWN_LD;
  end

  // Stage p0: macro pins driven straight from the granted port
  assign mem_ce  = if_gnt | ld_gnt;
  assign mem_oce = 1'b1;
  assign mem_wre = ld_gnt & ld_we;
  assign mem_ad  = if_gnt ? if_addr : (ld_gnt ? ld_addr : '0);
  assign mem_din = ld_wdata;

  // Stage p1: read data returns one cycle later, steered by the recorded owner
  assign if_rvalid = (rd_owner_p1 == OWN_IF);
  assign ld_rvalid = (rd_owner_p1 == OWN_LD);
  assign if_rdata  = mem_dout;
  assign ld_rdata  = mem_dout;
  assign boot_busy = (state == ST_BOOT);

endmodule
